// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU and load/MDU writeback streams onto one registered
// register-file write port, tracks pending long-latency destinations and forwards the in-flight write.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic            o_lsu_ready,
    input  logic            i_alloc_valid,
    input  logic [4:0]      i_alloc_rd,
    output logic [31:0]     o_busy,
    output logic            o_rd_wren,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic            o_rs1_fwd_valid,
    output logic            o_rs2_fwd_valid,
    output logic [XLEN-1:0] o_rs1_fwd_data,
    output logic [XLEN-1:0] o_rs2_fwd_data
);
    logic            ptr_q, ptr_d;
    logic            wren_q, wren_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [31:0]     busy_q, busy_d;
    logic            alu_gnt, lsu_gnt, xfer;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    always_comb begin
        alu_gnt  = i_alu_valid && (!i_lsu_valid || !ptr_q);
        lsu_gnt  = i_lsu_valid && (!i_alu_valid || ptr_q);
        xfer     = alu_gnt || lsu_gnt;
        win_rd   = alu_gnt ? i_alu_rd : i_lsu_rd;
        win_data = alu_gnt ? i_alu_data : i_lsu_data;

        ptr_d = ptr_q;
        // A contested grant hands priority to the source that lost.
        if (i_alu_valid && i_lsu_valid) ptr_d = alu_gnt;

        wren_d = xfer && (win_rd != 5'd0);
        addr_d = xfer ? win_rd : addr_q;
        data_d = xfer ? win_data : data_q;

        // Clear first so a same-cycle alloc of the same register keeps the bit set.
        busy_d = busy_q;
        if (wren_d) busy_d[win_rd] = 1'b0;
        if (i_alloc_valid && (i_alloc_rd != 5'd0)) busy_d[i_alloc_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q  <= 1'b0;
            wren_q <= 1'b0;
            addr_q <= 5'd0;
            data_q <= '0;
            busy_q <= 32'd0;
        end else begin
            ptr_q  <= ptr_d;
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign o_alu_ready     = alu_gnt;
    assign o_lsu_ready     = lsu_gnt;
    assign o_busy          = busy_q;
    assign o_rd_wren       = wren_q;
    assign o_rd_addr       = addr_q;
    assign o_rd_data       = data_q;
    assign o_rs1_fwd_valid = wren_q && (addr_q == i_rs1_addr) && (i_rs1_addr != 5'd0);
    assign o_rs2_fwd_valid = wren_q && (addr_q == i_rs2_addr) && (i_rs2_addr != 5'd0);
    assign o_rs1_fwd_data  = data_q;
    assign o_rs2_fwd_data  = data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a behavioural model queues expected handshakes and
// write-port state, and a negedge monitor compares them against the DUT.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_alu_valid = 1'b0, i_lsu_valid = 1'b0, i_alloc_valid = 1'b0;
    logic [4:0]  i_alu_rd = 5'd0, i_lsu_rd = 5'd0, i_alloc_rd = 5'd0;
    logic [31:0] i_alu_data = 32'd0, i_lsu_data = 32'd0;
    logic [4:0]  i_rs1_addr = 5'd0, i_rs2_addr = 5'd0;
    logic        o_alu_ready, o_lsu_ready, o_rd_wren, o_rs1_fwd_valid, o_rs2_fwd_valid;
    logic [31:0] o_busy, o_rd_data, o_rs1_fwd_data, o_rs2_fwd_data;
    logic [4:0]  o_rd_addr;

    wb_arbiter #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
        .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data), .o_lsu_ready(o_lsu_ready),
        .i_alloc_valid(i_alloc_valid), .i_alloc_rd(i_alloc_rd), .o_busy(o_busy),
        .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_fwd_valid(o_rs1_fwd_valid), .o_rs2_fwd_valid(o_rs2_fwd_valid),
        .o_rs1_fwd_data(o_rs1_fwd_data), .o_rs2_fwd_data(o_rs2_fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] busy;
    } exp_t;

    exp_t       oq[$];
    logic [1:0] rq[$];
    exp_t       pend;
    bit         have_pend = 1'b0;
    bit         mon_en = 1'b0;
    int         n_tests = 0, n_fail = 0;

    // Reference model state: who is favoured under contention, busy set, last written slot.
    bit          fav_lsu = 1'b0;
    logic [31:0] mbusy = 32'd0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input bit alv, input logic [4:0] alrd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         output bit ga, output bit gl);
        @(posedge clk);
        #1;
        if (have_pend) oq.push_back(pend);
        have_pend = 1'b1;
        i_alu_valid = av;  i_alu_rd = ard;  i_alu_data = ad;
        i_lsu_valid = lv;  i_lsu_rd = lrd;  i_lsu_data = ld;
        i_alloc_valid = alv; i_alloc_rd = alrd;
        i_rs1_addr = rs1;  i_rs2_addr = rs2;
        if (av && lv) begin
            ga = !fav_lsu;
            gl = fav_lsu;
            fav_lsu = !fav_lsu;
        end else begin
            ga = av;
            gl = lv;
        end
        rq.push_back({ga, gl});
        if (ga || gl) begin
            m_addr = ga ? ard : lrd;
            m_data = ga ? ad : ld;
            pend.wren = (m_addr != 5'd0);
            if (m_addr != 5'd0) mbusy[m_addr] = 1'b0;
        end else begin
            pend.wren = 1'b0;
        end
        if (alv && alrd != 5'd0) mbusy[alrd] = 1'b1;
        pend.addr = m_addr;
        pend.data = m_data;
        pend.busy = mbusy;
    endtask

    task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
        bit ga, gl;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, rs1, rs2, ga, gl);
    endtask

    logic [1:0] mr;
    exp_t       me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rq.size() != 0) begin
                mr = rq.pop_front();
                chk("alu_ready", 32'(o_alu_ready), 32'(mr[1]));
                chk("lsu_ready", 32'(o_lsu_ready), 32'(mr[0]));
            end
            if (oq.size() != 0) begin
                me = oq.pop_front();
                chk("rd_wren", 32'(o_rd_wren), 32'(me.wren));
                chk("rd_addr", 32'(o_rd_addr), 32'(me.addr));
                chk("rd_data", o_rd_data, me.data);
                chk("busy", o_busy, me.busy);
                chk("rs1_fwd_valid", 32'(o_rs1_fwd_valid),
                    32'(me.wren && me.addr == i_rs1_addr && i_rs1_addr != 5'd0));
                chk("rs2_fwd_valid", 32'(o_rs2_fwd_valid),
                    32'(me.wren && me.addr == i_rs2_addr && i_rs2_addr != 5'd0));
                chk("rs1_fwd_data", o_rs1_fwd_data, me.data);
                chk("rs2_fwd_data", o_rs2_fwd_data, me.data);
            end
        end
    end

    initial begin
        bit          ga, gl, ap, lp;
        logic [4:0]  ard, lrd;
        logic [31:0] ad, ld;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_wren", 32'(o_rd_wren), 32'd0);
        chk("reset_addr", 32'(o_rd_addr), 32'd0);
        chk("reset_data", o_rd_data, 32'd0);
        chk("reset_busy", o_busy, 32'd0);
        i_rst = 1'b0;
        mon_en = 1'b1;

        // x0 write is accepted but never reaches the register file.
        drive(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        idle(5'd0, 5'd0);
        // Scoreboard alloc, clear, and same-cycle alloc+clear.
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd0, 5'd0, ga, gl);
        drive(0, 5'd0, 32'd0, 1, 5'd7, 32'h7777, 0, 5'd0, 5'd0, 5'd0, ga, gl);
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h9999, 1, 5'd9, 5'd0, 5'd0, ga, gl);
        idle(5'd0, 5'd0);
        // Forwarding of the in-flight write, then no hit once it retires.
        drive(1, 5'd12, 32'h0000ABCD, 0, 5'd0, 32'd0, 0, 5'd0, 5'd12, 5'd13, ga, gl);
        idle(5'd12, 5'd13);
        idle(5'd12, 5'd13);
        // Back-to-back LSU writes with ALU idle.
        for (int i = 1; i <= 3; i++)
            drive(0, 5'd0, 32'd0, 1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 5'(i), 5'd2, ga, gl);

        // Contested grant moves priority to LSU, then reset mid-stream with wren=1, busy[5]=1.
        drive(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 1, 5'd5, 5'd6, 5'd0, ga, gl);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        i_lsu_valid = 1'b0; i_alloc_valid = 1'b0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd10; i_alu_data = 32'hAA;
        chk("pre_rst_wren", 32'(o_rd_wren), 32'd1);
        chk("pre_rst_busy5", 32'(o_busy[5]), 32'd1);
        #1;
        i_rst = 1'b1;
        #1;
        chk("async_rst_wren", 32'(o_rd_wren), 32'd0);
        chk("async_rst_addr", 32'(o_rd_addr), 32'd0);
        chk("async_rst_data", o_rd_data, 32'd0);
        chk("async_rst_busy", o_busy, 32'd0);
        chk("async_rst_fwd", 32'(o_rs1_fwd_valid), 32'd0);
        chk("rst_alu_ready", 32'(o_alu_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_xfer_lost_wren", 32'(o_rd_wren), 32'd0);
        chk("rst_xfer_lost_addr", 32'(o_rd_addr), 32'd0);
        i_alu_valid = 1'b0;
        i_rst = 1'b0;
        oq.delete();
        rq.delete();
        have_pend = 1'b0;
        fav_lsu = 1'b0; mbusy = 32'd0; m_addr = 5'd0; m_data = 32'd0;
        mon_en = 1'b1;

        // Contention: ALU rd3 / LSU rd4, ALU refreshes each cycle, LSU holds until granted.
        ad = 32'h11; ld = 32'h22;
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd3, ad, 1, 5'd4, ld, 0, 5'd0, 5'd3, 5'd4, ga, gl);
            ad = ad + 32'h100;
            if (gl) ld = ld + 32'h100;
        end
        idle(5'd0, 5'd0);

        // Randomized traffic; pending requests are held stable until granted.
        ap = 0; lp = 0; ard = 0; lrd = 0; ad = 0; ld = 0;
        for (int i = 0; i < 400; i++) begin
            bit         alv;
            logic [4:0] alrd, rs1, rs2;
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap = 1; ard = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!lp && $urandom_range(0, 2) != 0) begin
                lp = 1; lrd = 5'($urandom_range(0, 31)); ld = $urandom;
            end
            alv  = ($urandom_range(0, 3) == 0);
            alrd = 5'($urandom_range(0, 31));
            rs1  = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
            rs2  = 5'($urandom_range(0, 31));
            drive(ap, ard, ad, lp, lrd, ld, alv, alrd, rs1, rs2, ga, gl);
            if (ga) ap = 0;
            if (gl) lp = 0;
        end
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        @(negedge clk);
        #1;
        chk("queues_drained", 32'(oq.size() + rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard that drives the register file write port (`i_rd_wren`/`i_rd_addr`/`i_rd_data`). It merges two writeback sources, the single-cycle ALU path and the variable-latency load/MDU path, onto the single write port through a registered output stage. It tracks pending long-latency destinations in a 32-bit busy scoreboard. It also forwards the in-flight write to the decode-stage read addresses, covering the one cycle before the register file holds the value.

## Interface
- XLEN, 32, data width of all writeback data paths.
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_alu_valid  in  1  ALU writeback request.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  XLEN  ALU result.
- o_alu_ready  out  1  ALU request accepted this cycle.
- i_lsu_valid  in  1  load/MDU writeback request.
- i_lsu_rd  in  5  load/MDU destination register.
- i_lsu_data  in  XLEN  load/MDU result.
- o_lsu_ready  out  1  load/MDU request accepted this cycle.
- i_alloc_valid  in  1  long-latency op issued; mark destination busy.
- i_alloc_rd  in  5  destination being allocated.
- o_busy  out  32  scoreboard; bit n = register n has a pending long-latency write.
- o_rd_wren  out  1  register file write enable.
- o_rd_addr  out  5  register file write address.
- o_rd_data  out  XLEN  register file write data.
- i_rs1_addr, i_rs2_addr  in  5 each  decode read addresses.
- o_rs1_fwd_valid, o_rs2_fwd_valid  out  1 each  forward hit.
- o_rs1_fwd_data, o_rs2_fwd_data  out  XLEN each  forwarded data.

## Operation
- **Handshake:** a transfer occurs when valid and ready are both high at a rising edge.
  - Sources hold valid, rd and data stable until the transfer.
  - Ready may depend combinationally on either valid. Valid must never depend on ready.
- **Arbitration:** at most one grant per cycle.
  - Only one source valid: that source is granted.
  - Both valid: the round-robin pointer decides. The pointer is 0 = ALU first, 1 = LSU first.
  - After a contested grant, the pointer moves to the loser.
  - An uncontested grant does not change the pointer.
  - Ready is low for a source that is not granted.
- **Output stage:** on a transfer, the output register loads rd and data.
  - o_rd_wren is set to 1 if rd != 0, otherwise 0. A write to x0 is consumed and dropped.
  - With no transfer, o_rd_wren is 0 next cycle. o_rd_addr and o_rd_data hold their last values.
- **Scoreboard:**
  - i_alloc_valid with i_alloc_rd != 0 sets busy[i_alloc_rd] at the edge.
  - A transfer from either source with rd != 0 clears busy[rd] at the same edge.
  - Alloc and clear of the same rd in the same cycle: alloc wins and the bit stays 1.
  - Alloc of an already-busy rd leaves it 1. There is a single bit, no count, so upstream must stall on busy.
  - busy[0] is constant 0.
- **Forwarding (combinational):**
  - o_rsN_fwd_valid = o_rd_wren && o_rd_addr == i_rsN_addr && i_rsN_addr != 0.
  - o_rsN_fwd_data = o_rd_data, independent of valid.

## Timing
- **Reset (asynchronous, i_rst high):**
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_busy=0, pointer=0.
  - Ready outputs follow valids combinationally even during reset, but no transfer takes effect while i_rst is high.
  - A transfer in progress when reset asserts is lost. Sources must re-present after reset.
- **Latency:**
  - Transfer at edge N: o_rd_wren is high during cycle N to N+1, and the register file writes at edge N+1.
  - Forward hit is valid during cycle N to N+1.
  - The busy bit reads 0 from cycle N onward.
- **Throughput:** one write per cycle, sustained. Under continuous contention, grants alternate ALU/LSU.
- **No-op cycle:** with no valid input, o_rd_wren drops to 0 at the next edge. A forward hit occurs only while o_rd_wren=1.

## Test plan
- **Reset:** assert i_rst mid-stream with o_rd_wren=1 and busy[5]=1 -> all outputs 0 immediately (asynchronous), pointer=0. After release, a single ALU request is granted first.
- **Contention:** ALU (rd=3, 0x11) and LSU (rd=4, 0x22) valid together for 4 cycles, with fresh data each cycle -> grants ALU, LSU, ALU, LSU. o_rd_addr sequence 3,4,3,4 one cycle after each grant. Each held request is accepted only after its grant.
- **x0 drop:** ALU rd=0, data 0xDEADBEEF -> o_alu_ready=1, o_rd_wren stays 0, no forward hit for i_rs1_addr=0.
- **Scoreboard:**
  - alloc rd=7 -> busy=0x80.
  - LSU rd=7 transfer -> busy=0 at that edge.
  - alloc rd=9 together with LSU rd=9 transfer -> busy[9]=1.
- **Forwarding:** ALU rd=12, 0x0000_ABCD accepted at edge N, with i_rs1_addr=12 and i_rs2_addr=13 -> in cycle N: o_rs1_fwd_valid=1, o_rs1_fwd_data=0xABCD, o_rs2_fwd_valid=0. In cycle N+1 with no new transfer: o_rs1_fwd_valid=0.
- **Back-to-back single source:** LSU valid for 3 cycles with rd=1,2,3 and the ALU idle -> ready high every cycle. o_rd_wren high for 3 consecutive cycles with addr 1,2,3, and the pointer is unchanged.
